// File: rtl/bank_dma_engine_pkg.sv
// Shared types for the bank block-move engine: FSM states and operation modes.
package bank_dma_engine_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SETUP,
        S_RD_CLKH,
        S_RD_CLKL,
        S_WR_SETUP,
        S_WR_CLKH,
        S_WR_CLKL,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_COPY = 1'b1;

endpackage

// File: rtl/bank_dma_engine_port_mux.sv
// Expands one logical SRAM port onto the flattened per-bank buses and picks the
// read slice of the selected bank.
module bank_port_mux #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int NUM_BANKS = 4,
    parameter int BSEL_W    = 2
) (
    input  logic [BSEL_W-1:0]           bank,
    input  logic                        active,
    input  logic [ADDR_W-1:0]           ad,
    input  logic [DATA_W-1:0]           din,
    input  logic                        ce,
    input  logic                        wre,
    input  logic                        oce,
    input  logic                        clk,
    input  logic [NUM_BANKS*DATA_W-1:0] dout_bus,
    output logic [NUM_BANKS-1:0]        sel,
    output logic [NUM_BANKS*ADDR_W-1:0] ad_bus,
    output logic [NUM_BANKS*DATA_W-1:0] din_bus,
    output logic [NUM_BANKS-1:0]        ce_bus,
    output logic [NUM_BANKS-1:0]        wre_bus,
    output logic [NUM_BANKS-1:0]        oce_bus,
    output logic [NUM_BANKS-1:0]        clk_bus,
    output logic [DATA_W-1:0]           rdata
);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign sel[b] = active && (bank == BSEL_W'(b));
        assign ad_bus[b*ADDR_W +: ADDR_W]  = sel[b] ? ad  : '0;
        assign din_bus[b*DATA_W +: DATA_W] = sel[b] ? din : '0;
        assign ce_bus[b]  = sel[b] & ce;
        assign wre_bus[b] = sel[b] & wre;
        assign oce_bus[b] = sel[b] & oce;
        assign clk_bus[b] = sel[b] & clk;
    end

    // An out-of-range index reads as zero.
    always_comb begin
        rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (bank == BSEL_W'(b)) rdata = dout_bus[b*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/bank_dma_engine.sv
// Block-move engine: fills a bank range with a constant or copies a range between
// banks using the core's three-phase SRAM access (setup, clk high, clk low).
module bank_dma_engine
    import bank_dma_engine_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int NUM_BANKS = 4,
    parameter int BSEL_W    = 2
) (
    input  logic                        sysclk,
    input  logic                        arduino_reset_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        mode,
    input  logic [BSEL_W-1:0]           src_bank,
    input  logic [BSEL_W-1:0]           dst_bank,
    input  logic [ADDR_W-1:0]           src_addr,
    input  logic [ADDR_W-1:0]           dst_addr,
    input  logic [ADDR_W:0]             length,
    input  logic [DATA_W-1:0]           fill_value,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        aborted,
    input  logic [NUM_BANKS*DATA_W-1:0] mem_dout,
    output logic [NUM_BANKS*DATA_W-1:0] mem_din,
    output logic [NUM_BANKS*ADDR_W-1:0] mem_ad,
    output logic [NUM_BANKS-1:0]        mem_ce,
    output logic [NUM_BANKS-1:0]        mem_wre,
    output logic [NUM_BANKS-1:0]        mem_oce,
    output logic [NUM_BANKS-1:0]        mem_clk
);

    localparam logic [BSEL_W:0] NB = (BSEL_W+1)'(NUM_BANKS);

    state_t              state, nstate;
    logic                mode_r, err_r, aborted_r;
    logic [BSEL_W-1:0]   src_r, dst_r;
    logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
    logic [ADDR_W:0]     remaining;
    logic [DATA_W-1:0]   fill_r, buf_r, rd_data, wr_data, unused_wr_rdata;
    logic                bad, working;
    logic                rd_act, rd_en, rd_clk, wr_act, wr_en, wr_clk;

    assign bad = ({1'b0, dst_bank} >= NB) || ((mode == MODE_COPY) && ({1'b0, src_bank} >= NB));
    assign working = (state != S_IDLE) && (state != S_DONE);

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:
                if (start) begin
                    if (bad || length == '0) nstate = S_DONE;
                    else if (mode == MODE_COPY) nstate = S_RD_SETUP;
                    else nstate = S_WR_SETUP;
                end
            S_RD_SETUP: nstate = S_RD_CLKH;
            S_RD_CLKH:  nstate = S_RD_CLKL;
            S_RD_CLKL:  nstate = S_WR_SETUP;
            S_WR_SETUP: nstate = S_WR_CLKH;
            S_WR_CLKH:  nstate = S_WR_CLKL;
            S_WR_CLKL:  nstate = S_NEXT;
            S_NEXT:
                if (remaining == (ADDR_W+1)'(1)) nstate = S_DONE;
                else if (mode_r == MODE_COPY) nstate = S_RD_SETUP;
                else nstate = S_WR_SETUP;
            S_DONE:     if (!start) nstate = S_IDLE;
            default:    nstate = S_IDLE;
        endcase
        if (working && abort) nstate = S_DONE;
    end

    always_ff @(posedge sysclk or negedge arduino_reset_n) begin
        if (!arduino_reset_n) begin
            state     <= S_IDLE;
            mode_r    <= 1'b0;
            src_r     <= '0;
            dst_r     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            remaining <= '0;
            fill_r    <= '0;
            buf_r     <= '0;
            err_r     <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state <= nstate;
            case (state)
                S_IDLE:
                    if (start) begin
                        mode_r    <= mode;
                        src_r     <= src_bank;
                        dst_r     <= dst_bank;
                        rd_ptr    <= src_addr;
                        wr_ptr    <= dst_addr;
                        remaining <= length;
                        fill_r    <= fill_value;
                        err_r     <= bad;
                        aborted_r <= 1'b0;
                    end
                S_RD_CLKL: buf_r <= rd_data;
                S_NEXT: begin
                    rd_ptr    <= rd_ptr + ADDR_W'(1);
                    wr_ptr    <= wr_ptr + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W+1)'(1);
                end
                S_DONE:
                    if (!start) begin
                        err_r     <= 1'b0;
                        aborted_r <= 1'b0;
                    end
                default: ;
            endcase
            if (working && abort) aborted_r <= 1'b1;
        end
    end

    assign busy    = working;
    assign done    = (state == S_DONE);
    assign err     = err_r;
    assign aborted = aborted_r;

    // Enables span setup and clk-high so the bank sees them stable across its rising clock.
    assign rd_act  = (state == S_RD_SETUP) || (state == S_RD_CLKH) || (state == S_RD_CLKL);
    assign rd_en   = (state == S_RD_SETUP) || (state == S_RD_CLKH);
    assign rd_clk  = (state == S_RD_CLKH);
    assign wr_act  = (state == S_WR_SETUP) || (state == S_WR_CLKH) || (state == S_WR_CLKL);
    assign wr_en   = (state == S_WR_SETUP) || (state == S_WR_CLKH);
    assign wr_clk  = (state == S_WR_CLKH);
    assign wr_data = (mode_r == MODE_COPY) ? buf_r : fill_r;

    logic [NUM_BANKS-1:0]        rd_sel, wr_sel, rd_ce, wr_ce, rd_wre, wr_wre;
    logic [NUM_BANKS-1:0]        rd_oce, wr_oce, rd_clkb, wr_clkb;
    logic [NUM_BANKS*ADDR_W-1:0] rd_ad, wr_ad, ad_or, ad_q;
    logic [NUM_BANKS*DATA_W-1:0] unused_rd_din, wr_din, din_q;

    bank_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .BSEL_W(BSEL_W)) u_rd_port (
        .bank(src_r), .active(rd_act), .ad(rd_ptr), .din('0), .ce(rd_en), .wre(1'b0),
        .oce(rd_en), .clk(rd_clk), .dout_bus(mem_dout), .sel(rd_sel), .ad_bus(rd_ad),
        .din_bus(unused_rd_din), .ce_bus(rd_ce), .wre_bus(rd_wre), .oce_bus(rd_oce),
        .clk_bus(rd_clkb), .rdata(rd_data)
    );

    bank_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .BSEL_W(BSEL_W)) u_wr_port (
        .bank(dst_r), .active(wr_act), .ad(wr_ptr), .din(wr_data), .ce(wr_en), .wre(wr_en),
        .oce(1'b0), .clk(wr_clk), .dout_bus(mem_dout), .sel(wr_sel), .ad_bus(wr_ad),
        .din_bus(wr_din), .ce_bus(wr_ce), .wre_bus(wr_wre), .oce_bus(wr_oce),
        .clk_bus(wr_clkb), .rdata(unused_wr_rdata)
    );

    assign mem_ce  = rd_ce | wr_ce;
    assign mem_wre = rd_wre | wr_wre;
    assign mem_oce = rd_oce | wr_oce;
    assign mem_clk = rd_clkb | wr_clkb;
    assign ad_or   = rd_ad | wr_ad;

    // Banks not driven this cycle keep their last address/data.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_out
        assign mem_ad[b*ADDR_W +: ADDR_W] = (rd_sel[b] | wr_sel[b]) ? ad_or[b*ADDR_W +: ADDR_W]
                                                                    : ad_q[b*ADDR_W +: ADDR_W];
        assign mem_din[b*DATA_W +: DATA_W] = wr_sel[b] ? wr_din[b*DATA_W +: DATA_W]
                                                       : din_q[b*DATA_W +: DATA_W];
    end

    always_ff @(posedge sysclk or negedge arduino_reset_n) begin
        if (!arduino_reset_n) begin
            ad_q  <= '0;
            din_q <= '0;
        end else begin
            ad_q  <= mem_ad;
            din_q <= mem_din;
        end
    end

endmodule

// File: tb/tb_bank_dma_engine.sv
// Bench for bank_dma_engine: four behavioural banks, a memory/write-order model
// and a per-cycle compare of bank traffic against it.
module tb_bank_dma_engine;

    localparam int AW = 4, DW = 8, NB = 4, BW = 3;

    logic              sysclk = 1'b0;
    logic              arduino_reset_n;
    logic              start, abort, mode;
    logic [BW-1:0]     src_bank, dst_bank;
    logic [AW-1:0]     src_addr, dst_addr;
    logic [AW:0]       length;
    logic [DW-1:0]     fill_value;
    logic              busy, done, err, aborted;
    logic [NB*DW-1:0]  mem_dout, mem_din;
    logic [NB*AW-1:0]  mem_ad;
    logic [NB-1:0]     mem_ce, mem_wre, mem_oce, mem_clk;

    always #5 sysclk = ~sysclk;

    bank_dma_engine #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(NB), .BSEL_W(BW)) dut (
        .sysclk(sysclk), .arduino_reset_n(arduino_reset_n), .start(start), .abort(abort),
        .mode(mode), .src_bank(src_bank), .dst_bank(dst_bank), .src_addr(src_addr),
        .dst_addr(dst_addr), .length(length), .fill_value(fill_value), .busy(busy),
        .done(done), .err(err), .aborted(aborted), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_ad(mem_ad), .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_oce(mem_oce), .mem_clk(mem_clk)
    );

    // Behavioural banks plus a preload back door.
    logic [7:0] bmem [4][16];
    logic [7:0] bdout [4];
    logic       pre_stb;
    int         pre_b, pre_a;
    logic [7:0] pre_d;

    always @(posedge mem_clk[0] or posedge mem_clk[1] or posedge mem_clk[2] or
             posedge mem_clk[3] or posedge pre_stb) begin
        if (pre_stb) bmem[pre_b][pre_a] = pre_d;
        else for (int b = 0; b < 4; b++)
            if (mem_clk[b] && mem_ce[b]) begin
                if (mem_wre[b]) bmem[b][mem_ad[b*4 +: 4]] = mem_din[b*8 +: 8];
                else bdout[b] = bmem[b][mem_ad[b*4 +: 4]];
            end
    end
    assign mem_dout = {bdout[3], bdout[2], bdout[1], bdout[0]};

    typedef struct { int b; int a; logic [7:0] d; } wr_t;
    logic [7:0] model [4][16];
    wr_t        exp_q[$];
    int         wr_idx, n_chk, n_pass;
    logic [3:0] allow;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    task automatic preload(input int b, input int a, input logic [7:0] d);
        pre_b = b; pre_a = a; pre_d = d; model[b][a] = d;
        #1 pre_stb = 1'b1;
        #1 pre_stb = 1'b0;
    endtask

    // One cycle: step to the falling edge and compare bank traffic with the model.
    task automatic tick();
        @(negedge sysclk);
        chk("ce_outside_banks", 64'(mem_ce & ~allow), 64'(0));
        chk("busy_done_excl", 64'(busy & done), 64'(0));
        for (int b = 0; b < 4; b++)
            if (mem_clk[b] && mem_ce[b] && mem_wre[b]) begin
                if (wr_idx < exp_q.size()) begin
                    chk("wr_bank", 64'(b), 64'(exp_q[wr_idx].b));
                    chk("wr_addr", 64'(mem_ad[b*4 +: 4]), 64'(exp_q[wr_idx].a));
                    chk("wr_data", 64'(mem_din[b*8 +: 8]), 64'(exp_q[wr_idx].d));
                end else chk("wr_count", 64'(wr_idx + 1), 64'(exp_q.size()));
                wr_idx++;
            end
    endtask

    task automatic cmp_mem(input string nm);
        for (int b = 0; b < 4; b++) begin
            int mism = 0;
            for (int a = 0; a < 16; a++) if (bmem[b][a] !== model[b][a]) mism++;
            chk({nm, "_bank_mism"}, 64'(mism), 64'(0));
        end
    endtask

    task automatic do_op(input string nm, input bit m, input int sb, input int db, input int sa,
                         input int da, input int len, input logic [7:0] fv, input int abort_el,
                         input bit exp_err, input int exp_busy);
        int  n_el, setups, bcnt;
        bit  got_done;
        n_el = (abort_el >= 0) ? abort_el : len;
        exp_q.delete();
        wr_idx = 0;
        if (!exp_err)
            for (int i = 0; i < n_el; i++) begin
                wr_t w;
                w.b = db; w.a = (da + i) % 16;
                w.d = m ? model[sb][(sa + i) % 16] : fv;
                model[db][w.a] = w.d;
                exp_q.push_back(w);
            end
        allow = exp_err ? 4'b0 : (4'(1 << db) | (m ? 4'(1 << sb) : 4'b0));
        mode = m; src_bank = 3'(sb); dst_bank = 3'(db); src_addr = 4'(sa); dst_addr = 4'(da);
        length = 5'(len); fill_value = fv; start = 1'b1;
        bcnt = 0; setups = 0; got_done = 0;
        for (int c = 0; c < 2000 && !got_done; c++) begin
            tick();
            abort = 1'b0;
            if (busy) bcnt++;
            if (done) got_done = 1;
            else if (abort_el >= 0 && mem_ce[db] && mem_wre[db] && !mem_clk[db]) begin
                setups++;
                if (setups == abort_el + 1) abort = 1'b1;
            end
        end
        chk({nm, "_done"}, 64'(got_done), 64'(1));
        chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        chk({nm, "_err"}, 64'(err), 64'(exp_err));
        chk({nm, "_aborted"}, 64'(aborted), 64'(abort_el >= 0));
        chk({nm, "_ctl_idle"}, 64'({mem_ce, mem_wre, mem_oce, mem_clk}), 64'(0));
        chk({nm, "_writes"}, 64'(wr_idx), 64'(exp_q.size()));
        cmp_mem(nm);
        tick();
        chk({nm, "_hold_done"}, 64'({done, busy}), 64'(2'b10));
        start = 1'b0;
        tick();
        chk({nm, "_to_idle"}, 64'({busy, done, err, aborted}), 64'(0));
        allow = 4'b0;
    endtask

    initial begin
        bit found;
        n_chk = 0; n_pass = 0; wr_idx = 0; allow = 4'b0;
        start = 0; abort = 0; mode = 0; src_bank = 0; dst_bank = 0;
        src_addr = 0; dst_addr = 0; length = 0; fill_value = 0;
        pre_stb = 0; arduino_reset_n = 1'b0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 16; a++) preload(b, a, 8'(b * 16 + a * 3 + 1));
        chk("rst_status", 64'({busy, done, err, aborted}), 64'(0));
        chk("rst_ctl", 64'({mem_ce, mem_wre, mem_oce, mem_clk}), 64'(0));
        chk("rst_ad", 64'(mem_ad), 64'(0));
        chk("rst_din", 64'(mem_din), 64'(0));
        @(negedge sysclk) arduino_reset_n = 1'b1;
        tick();

        do_op("fill_b3", 1'b0, 0, 3, 0, 0, 16, 8'hA5, -1, 1'b0, 64);
        chk("fill_b3_lit", 64'(bmem[3][7]), 64'hA5);

        do_op("copy_wrap", 1'b1, 0, 1, 2, 14, 4, 8'h00, -1, 1'b0, 28);
        chk("copy_lit14", 64'(bmem[1][14]), 64'd7);
        chk("copy_lit1", 64'(bmem[1][1]), 64'd16);

        preload(2, 0, 8'h11);
        do_op("copy_same", 1'b1, 2, 2, 0, 1, 3, 8'h00, -1, 1'b0, 21);
        chk("copy_same_lit", 64'({bmem[2][1], bmem[2][2], bmem[2][3]}), 64'h111111);

        do_op("len0", 1'b0, 0, 0, 3, 3, 0, 8'h5A, -1, 1'b0, 0);
        do_op("bad_dst", 1'b0, 0, 4, 0, 0, 5, 8'h5A, -1, 1'b1, 0);
        do_op("bad_src", 1'b1, 5, 1, 0, 0, 2, 8'h00, -1, 1'b1, 0);

        do_op("abort", 1'b0, 0, 3, 0, 0, 16, 8'h3C, 4, 1'b0, 17);
        chk("abort_lit3", 64'(bmem[3][3]), 64'h3C);
        chk("abort_lit4", 64'(bmem[3][4]), 64'hA5);

        // Reset during the first write pulse of a copy.
        exp_q.delete();
        wr_idx = 0;
        begin
            wr_t w;
            w.b = 0; w.a = 8; w.d = model[1][0];
            model[0][8] = w.d;
            exp_q.push_back(w);
        end
        allow = 4'b0011;
        mode = 1'b1; src_bank = 3'd1; dst_bank = 3'd0; src_addr = 4'd0; dst_addr = 4'd8;
        length = 5'd4; start = 1'b1;
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            tick();
            if (mem_clk[0] && mem_wre[0]) found = 1;
        end
        chk("rst_mid_reached", 64'(found), 64'(1));
        #1 arduino_reset_n = 1'b0;
        #1;
        chk("rst_mid_status", 64'({busy, done, err, aborted}), 64'(0));
        chk("rst_mid_ctl", 64'({mem_ce, mem_wre, mem_oce, mem_clk}), 64'(0));
        chk("rst_mid_ad", 64'(mem_ad), 64'(0));
        start = 1'b0;
        tick();
        arduino_reset_n = 1'b1;
        chk("rst_mid_writes", 64'(wr_idx), 64'(1));
        cmp_mem("rst_mid");
        allow = 4'b0;
        tick();

        do_op("fill_after_rst", 1'b0, 0, 2, 0, 5, 3, 8'h77, -1, 1'b0, 12);
        chk("fill_after_rst_lit", 64'(bmem[2][7]), 64'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
